// File: rtl/ahb_csr_slave.sv
// AHB-Lite responder for a bank of 32-bit control/status registers with
// programmable wait states, two-cycle ERROR responses and per-register strobes.
module ahb_csr_slave #(
    parameter int NUM_REGS    = 16,
    parameter int NUM_RW      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic [31:0]                        haddr_i,
    input  logic                               hwrite_i,
    input  logic [2:0]                         hsize_i,
    input  logic [2:0]                         hburst_i,
    input  logic [3:0]                         hprot_i,
    input  logic [1:0]                         htrans_i,
    input  logic                               hmastlock_i,
    input  logic [31:0]                        hwdata_i,
    output logic                               hready_o,
    output logic                               hresp_o,
    output logic [31:0]                        hrdata_o,
    output logic [32*NUM_RW-1:0]               ctrl_o,
    input  logic [32*(NUM_REGS-NUM_RW)-1:0]    status_i,
    output logic [NUM_REGS-1:0]                wr_pulse_o,
    output logic [NUM_REGS-1:0]                rd_pulse_o
);

    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int NUM_RO = NUM_REGS - NUM_RW;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                   state_q, state_d;
    logic [3:0]               waitCnt_q, waitCnt_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     write_q, write_d;
    logic [1:0]               size_q, size_d;
    logic [1:0]               lane_q, lane_d;
    logic [NUM_RW-1:0][31:0]  ctrl_q;
    logic [NUM_REGS-1:0]      wrPulse_q, rdPulse_q;

    logic [IDX_W-1:0]         addrIdx;
    logic                     sizeBad, misaligned, outOfRange, roWrite, accessLegal;
    logic                     ready, accept;
    logic [31:0]              laneMask, rdSel;
    logic                     unusedInputs;

    // Inputs the register bank has no use for (region select is done upstream).
    assign unusedInputs = ^{hburst_i, hprot_i, hmastlock_i, haddr_i[31:30], htrans_i[0]};

    assign addrIdx     = haddr_i[IDX_W+1:2];
    assign sizeBad     = (hsize_i > 3'd2);
    assign misaligned  = ((hsize_i == 3'd1) && haddr_i[0]) ||
                         ((hsize_i == 3'd2) && (haddr_i[1:0] != 2'b00));
    assign outOfRange  = (haddr_i[29:IDX_W+2] != '0) || (int'(addrIdx) >= NUM_REGS);
    assign roWrite     = hwrite_i && (int'(addrIdx) >= NUM_RW);
    assign accessLegal = !(sizeBad || misaligned || outOfRange || roWrite);

    assign ready    = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
    assign accept   = ready && htrans_i[1];
    assign hready_o = ready;
    assign hresp_o  = (state_q == ST_ERR1) || (state_q == ST_ERR2);

    // Any ready cycle doubles as an address phase, so DONE/ERR2 can chain transfers.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        idx_d     = idx_q;
        write_d   = write_q;
        size_d    = size_q;
        lane_d    = lane_q;
        case (state_q)
            ST_WAIT: begin
                if (waitCnt_q == 4'd0) state_d = ST_DONE;
                else                   waitCnt_d = waitCnt_q - 4'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = state_q;
        endcase
        if (ready) begin
            state_d = ST_IDLE;
            if (accept) begin
                idx_d   = addrIdx;
                write_d = hwrite_i;
                size_d  = hsize_i[1:0];
                lane_d  = haddr_i[1:0];
                if (!accessLegal) begin
                    state_d = ST_ERR1;
                end else if (WAIT_STATES > 0) begin
                    state_d   = ST_WAIT;
                    waitCnt_d = 4'(WAIT_STATES - 1);
                end else begin
                    state_d = ST_DONE;
                end
            end
        end
    end

    always_comb begin
        case (size_q)
            2'd0:    laneMask = 32'h0000_00FF << {lane_q, 3'b000};
            2'd1:    laneMask = 32'h0000_FFFF << {lane_q[1], 4'b0000};
            default: laneMask = 32'hFFFF_FFFF;
        endcase
    end

    always_comb begin
        rdSel = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (idx_q == IDX_W'(i)) rdSel = ctrl_q[i];
        end
        for (int i = 0; i < NUM_RO; i++) begin
            if (idx_q == IDX_W'(i + NUM_RW)) rdSel = status_i[i*32 +: 32];
        end
    end

    assign hrdata_o   = ((state_q == ST_DONE) && !write_q) ? rdSel : 32'd0;
    assign ctrl_o     = ctrl_q;
    assign wr_pulse_o = wrPulse_q;
    assign rd_pulse_o = rdPulse_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            waitCnt_q <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            size_q    <= '0;
            lane_q    <= '0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            size_q    <= size_d;
            lane_q    <= lane_d;
        end
    end

    // The edge that ends DONE is where a write lands and where both strobes are launched.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl_q    <= '0;
            wrPulse_q <= '0;
            rdPulse_q <= '0;
        end else begin
            wrPulse_q <= '0;
            rdPulse_q <= '0;
            if (state_q == ST_DONE) begin
                if (write_q) begin
                    wrPulse_q <= NUM_REGS'(1) << idx_q;
                    for (int i = 0; i < NUM_RW; i++) begin
                        if (idx_q == IDX_W'(i))
                            ctrl_q[i] <= (ctrl_q[i] & ~laneMask) | (hwdata_i & laneMask);
                    end
                end else begin
                    rdPulse_q <= NUM_REGS'(1) << idx_q;
                end
            end
        end
    end

endmodule
